framebuffer_dbuf: RTL and testbench

- Double-buffered pixel store that sits directly downstream of spi_controller and upstream of the panel scan driver.
- Accepts pixel writes (wrow/wcol/wdata/wen) into the back bank and exposes `ready` to the SPI side.
- On `loaded`, swaps banks at the next scan frame boundary, so the scanner never displays a half-written frame.
- The scanner reads the front bank through a registered read port.

---
 rtl/framebuffer_dbuf.sv | 173 +++++++++++++++++
 tb/tb_framebuffer_dbuf.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_dbuf.sv
// framebuffer_dbuf
//   Double-buffered pixel store between the SPI receiver and the panel scan
//   driver. The SPI side fills the back bank; the scanner reads the front
//   bank. A completed back frame (loaded) is promoted to the front at the
//   next scanner frame boundary (frame_end), so a half-written frame is
//   never displayed.
//
// Optional build macro:
//   FRAMEBUFFER_CLEAR_ON_SWAP_EN - after every swap, zero the new back bank
//   (one address per cycle) before accepting writes again.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wrow/wcol/wdata   write address (global row, column) and {r,g,b} pixel
//   wen               write strobe, one cycle per pixel
//   loaded            pulse: back frame complete, request swap
//   ready             back bank writable and no swap pending
//   rrow/rcol/ren     scanner read address and strobe
//   rdata/rvalid      read data from the front bank, one cycle after ren
//   frame_end         pulse from the scanner: safe point to swap
//   swapped           pulse during the cycle the banks toggle
//   front_bank        index of the bank currently displayed
module framebuffer_dbuf #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int NR = segments * rows,
  localparam int RB = (NR > 1) ? $clog2(NR) : 1,
  localparam int CB = (columns > 1) ? $clog2(columns) : 1,
  localparam int PW = 3 * bitwidth
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RB-1:0] wrow,
  input  logic [CB-1:0] wcol,
  input  logic [PW-1:0] wdata,
  input  logic          wen,
  input  logic          loaded,
  output logic          ready,
  input  logic [RB-1:0] rrow,
  input  logic [CB-1:0] rcol,
  input  logic          ren,
  output logic [PW-1:0] rdata,
  output logic          rvalid,
  input  logic          frame_end,
  output logic          swapped,
  output logic          front_bank
);

  localparam int DEPTH = NR * columns;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = $clog2(2 * DEPTH);

  typedef enum logic [1:0] {FILL, PENDING, SWAP, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          front_bank_q, front_bank_d;
  logic          rvalid_q;
  logic [PW-1:0] rdata_q;

  // Both banks live in one array: bank b occupies [b*DEPTH, b*DEPTH+DEPTH).
  logic [PW-1:0] mem [0:2*DEPTH-1];

  logic          mem_we;
  logic [IW-1:0] mem_widx;
  logic [PW-1:0] mem_wdata;

  logic          wr_in_range, rd_in_range;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [IW-1:0] rd_idx;

  function automatic logic [IW-1:0] bank_idx(input logic bank, input logic [AW-1:0] addr);
    return IW'(bank ? (DEPTH + int'(addr)) : int'(addr));
  endfunction

  // Out-of-range coordinates are rejected explicitly so they never alias
  // onto another row through the linear address.
  assign wr_in_range = (int'(wrow) < NR) && (int'(wcol) < columns);
  assign rd_in_range = (int'(rrow) < NR) && (int'(rcol) < columns);
  assign wr_addr     = AW'(int'(wrow) * columns + int'(wcol));
  assign rd_addr     = AW'(int'(rrow) * columns + int'(rcol));
  assign rd_idx      = bank_idx(front_bank_q, rd_addr);

`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    mem_we       = 1'b0;
    mem_widx     = bank_idx(~front_bank_q, wr_addr);
    mem_wdata    = wdata;
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
    clr_cnt_d    = clr_cnt_q;
`endif
    case (state_q)
      FILL: begin
        // A write coincident with loaded still lands; frame_end is ignored here.
        mem_we = wen & wr_in_range;
        if (loaded) state_d = PENDING;
      end
      PENDING: begin
        if (frame_end) state_d = SWAP;
      end
      SWAP: begin
        front_bank_d = ~front_bank_q;
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
        state_d = CLEAR;
`else
        state_d = FILL;
`endif
      end
      CLEAR: begin
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
        // front_bank has already toggled, so ~front_bank_q is the new back bank.
        mem_we    = 1'b1;
        mem_widx  = bank_idx(~front_bank_q, clr_cnt_q);
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (int'(clr_cnt_q) == DEPTH - 1) begin
          clr_cnt_d = '0;
          state_d   = FILL;
        end
`else
        state_d = FILL;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      front_bank_q <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      rvalid_q     <= ren;
    end
  end

`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_cnt_q <= '0;
    else     clr_cnt_q <= clr_cnt_d;
  end
`endif

  // RAM contents are never reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_widx] <= mem_wdata;
  end

  // Registered read; rdata holds between reads and clears only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ren) begin
      rdata_q <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

  assign ready      = (state_q == FILL);
  assign swapped    = (state_q == SWAP);
  assign front_bank = front_bank_q;
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
module tb_framebuffer_dbuf;

  localparam int PW = 24;
`ifdef FRAMEBUFFER_CLEAR_ON_SWAP_EN
  localparam int CLR_A = 256;
  localparam int CLR_B = 198;
  localparam bit CLEARS = 1'b1;
`else
  localparam int CLR_A = 0;
  localparam int CLR_B = 0;
  localparam bit CLEARS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-configuration instance
  logic [2:0]    wrow, rrow;
  logic [4:0]    wcol, rcol;
  logic [PW-1:0] wdata, rdata;
  logic          wen, loaded, ready, ren, rvalid, frame_end, swapped, front_bank;

  // Instance with rows=6, columns=33 so out-of-range coordinates are encodable
  logic [2:0]    b_wrow, b_rrow;
  logic [5:0]    b_wcol, b_rcol;
  logic [PW-1:0] b_wdata, b_rdata;
  logic          b_wen, b_loaded, b_ready, b_ren, b_rvalid, b_frame_end, b_swapped, b_front_bank;

  framebuffer_dbuf dut (
    .clk(clk), .rst(rst),
    .wrow(wrow), .wcol(wcol), .wdata(wdata), .wen(wen), .loaded(loaded), .ready(ready),
    .rrow(rrow), .rcol(rcol), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .frame_end(frame_end), .swapped(swapped), .front_bank(front_bank)
  );

  framebuffer_dbuf #(.segments(1), .rows(6), .columns(33), .bitwidth(8)) dut_b (
    .clk(clk), .rst(rst),
    .wrow(b_wrow), .wcol(b_wcol), .wdata(b_wdata), .wen(b_wen), .loaded(b_loaded), .ready(b_ready),
    .rrow(b_rrow), .rcol(b_rcol), .ren(b_ren), .rdata(b_rdata), .rvalid(b_rvalid),
    .frame_end(b_frame_end), .swapped(b_swapped), .front_bank(b_front_bank)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_a[$];
  logic [PW-1:0] exp_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input int c, input logic [PW-1:0] d);
    wrow = 3'(r); wcol = 5'(c); wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input int r, input int c, input logic [PW-1:0] e);
    rrow = 3'(r); rcol = 5'(c); ren = 1'b1;
    exp_a.push_back(e);
    $display("read  A row=%0d col=%0d expect=%h", r, c, e);
    tick();
    ren = 1'b0;
  endtask

  task automatic wr_b(input int r, input int c, input logic [PW-1:0] d);
    b_wrow = 3'(r); b_wcol = 6'(c); b_wdata = d; b_wen = 1'b1;
    tick();
    b_wen = 1'b0;
  endtask

  task automatic rd_b(input int r, input int c, input logic [PW-1:0] e);
    b_rrow = 3'(r); b_rcol = 6'(c); b_ren = 1'b1;
    exp_b.push_back(e);
    $display("read  B row=%0d col=%0d expect=%h", r, c, e);
    tick();
    b_ren = 1'b0;
  endtask

  // Count cycles until ready returns (bounded).
  task automatic wait_ready_a(output int cnt);
    cnt = 0;
    while (!ready && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_ready_b(output int cnt);
    cnt = 0;
    while (!b_ready && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  // Scoreboard monitors: pop the expected value whenever the DUT presents rvalid.
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_a_unexpected: got rvalid=1 data=%h required no read", rdata);
      end else begin
        chk("rd_a_data", 32'(rdata), 32'(exp_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rvalid) begin
      if (exp_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_b_unexpected: got rvalid=1 data=%h required no read", b_rdata);
      end else begin
        chk("rd_b_data", 32'(b_rdata), 32'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    wrow = '0; wcol = '0; wdata = '0; wen = 1'b0; loaded = 1'b0;
    rrow = '0; rcol = '0; ren = 1'b0; frame_end = 1'b0;
    b_wrow = '0; b_wcol = '0; b_wdata = '0; b_wen = 1'b0; b_loaded = 1'b0;
    b_rrow = '0; b_rcol = '0; b_ren = 1'b0; b_frame_end = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_swapped", 32'(swapped), 32'd0);
    chk("rst_front", 32'(front_bank), 32'd0);
    rst = 1'b0;
    tick();

    // Frame A into bank 1
    for (int i = 0; i < 32; i++) wr(0, i, 24'hFFFF00 | 24'(i));
    wr(7, 31, 24'h0A0B0C);
    chk("a_ready_fill", 32'(ready), 32'd1);
    loaded = 1'b1; tick(); loaded = 1'b0;
    $display("loaded A");
    chk("a_ready_pending", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_swapped_wait", 32'(swapped), 32'd0);
      chk("a_ready_wait", 32'(ready), 32'd0);
    end
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("a_swapped_pulse", 32'(swapped), 32'd1);
    chk("a_front_in_swap", 32'(front_bank), 32'd0);
    tick();
    chk("a_swapped_drop", 32'(swapped), 32'd0);
    chk("a_front_after", 32'(front_bank), 32'd1);
    wait_ready_a(cnt);
    chk("a_clear_cycles", 32'(cnt), 32'(CLR_A));
    for (int i = 0; i < 32; i++) rd(0, i, 24'hFFFF00 | 24'(i));
    rd(7, 31, 24'h0A0B0C);

    // Frame B into bank 0; long pending with ignored writes
    wr(7, 31, 24'h111111);
    wr(0, 0, 24'h222222);
    wr(0, 1, 24'h333333);
    loaded = 1'b1; tick(); loaded = 1'b0;
    $display("loaded B, holding 100 cycles");
    for (int i = 0; i < 100; i++) begin
      wrow = 3'd0; wcol = 5'd1; wdata = 24'h123456; wen = 1'b1;
      loaded = (i == 50);
      tick();
      chk("b_hold_ready", 32'(ready), 32'd0);
      chk("b_hold_swapped", 32'(swapped), 32'd0);
      chk("b_hold_front", 32'(front_bank), 32'd1);
    end
    wen = 1'b0; loaded = 1'b0;
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("b_swapped_pulse", 32'(swapped), 32'd1);
    rd(7, 31, 24'h0A0B0C);          // issued in SWAP: old front bank
    chk("b_front_after", 32'(front_bank), 32'd0);
    chk("b_swapped_drop", 32'(swapped), 32'd0);
    rd(7, 31, 24'h111111);          // one cycle later: new front bank
    wait_ready_a(cnt);
    chk("b_clear_cycles", 32'(cnt), 32'(CLR_A));
    rd(0, 1, 24'h333333);
    rd(0, 0, 24'h222222);

    // Frame C into bank 1: write + loaded + frame_end all together
    wr(0, 5, 24'h555555);
    wrow = 3'd0; wcol = 5'd2; wdata = 24'h444444; wen = 1'b1;
    loaded = 1'b1; frame_end = 1'b1;
    tick();
    wen = 1'b0; loaded = 1'b0; frame_end = 1'b0;
    $display("loaded C with coincident frame_end");
    chk("c_ready_pending", 32'(ready), 32'd0);
    tick();
    chk("c_no_swap", 32'(swapped), 32'd0);
    tick();
    chk("c_no_swap2", 32'(swapped), 32'd0);
    chk("c_front_hold", 32'(front_bank), 32'd0);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("c_swapped_pulse", 32'(swapped), 32'd1);
    tick();
    chk("c_front_after", 32'(front_bank), 32'd1);
    wait_ready_a(cnt);
    chk("c_clear_cycles", 32'(cnt), 32'(CLR_A));
    rd(0, 2, 24'h444444);
    rd(0, 5, 24'h555555);
    rd(0, 3, CLEARS ? 24'h000000 : 24'hFFFF03);

    // Asynchronous reset while PENDING
    loaded = 1'b1; tick(); loaded = 1'b0;
    chk("r_ready_pending", 32'(ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("r_async_front", 32'(front_bank), 32'd0);
    chk("r_async_ready", 32'(ready), 32'd1);
    #3 rst = 1'b0;
    $display("async reset during pending");
    tick();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    chk("r_no_swap", 32'(swapped), 32'd0);
    chk("r_front", 32'(front_bank), 32'd0);
    chk("r_ready", 32'(ready), 32'd1);

    // Bounds on the rows=6, columns=33 instance
    wr_b(1, 7, 24'h0C0C0C);          // linear address 40
    wr_b(0, 0, 24'h0000AA);
    wr_b(0, 40, 24'hBBBBBB);         // col out of range: must not alias to row 1 col 7
    wr_b(6, 0, 24'hDDDDDD);          // row out of range
    b_loaded = 1'b1; tick(); b_loaded = 1'b0;
    b_frame_end = 1'b1; tick(); b_frame_end = 1'b0;
    chk("bnd_swapped", 32'(b_swapped), 32'd1);
    tick();
    chk("bnd_front", 32'(b_front_bank), 32'd1);
    wait_ready_b(cnt);
    chk("bnd_clear_cycles", 32'(cnt), 32'(CLR_B));
    rd_b(0, 0, 24'h0000AA);
    rd_b(1, 7, 24'h0C0C0C);
    rd_b(0, 40, 24'h000000);
    rd_b(6, 0, 24'h000000);
    rd_b(7, 3, 24'h000000);

    repeat (3) tick();
    chk("sb_drain", 32'(exp_a.size() + exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
